// File: rtl/column_reduce_if.sv
// Element-in / result-out bus for column_reduce: upstream ALU stream plus host result port.
interface column_reduce_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ACC_W  = 2 * DATA_W,
    parameter int unsigned CNT_W  = 16
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic                     in_last;
    logic [1:0]               op;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [ACC_W-1:0]  out_result;
    logic [CNT_W-1:0]         out_count;
    logic                     overflow;

    modport master (
        output in_valid, in_data, in_last, op, out_ready,
        input  in_ready, out_valid, out_result, out_count, overflow
    );

    modport slave (
        input  in_valid, in_data, in_last, op, out_ready,
        output in_ready, out_valid, out_result, out_count, overflow
    );
endinterface

// File: rtl/column_reduce.sv
// Reduces one frame of signed elements to a scalar (SUM/MIN/MAX/COUNT).
// COLUMN_REDUCE_SAT_EN: SUM clamps to the ACC_W range instead of wrapping.
module column_reduce #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ACC_W  = 2 * DATA_W,
    parameter int unsigned CNT_W  = 16
) (
    input logic            clk,
    input logic            reset_n,
    column_reduce_if.slave bus
);
    localparam int unsigned SUM_W = ACC_W + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    localparam logic [1:0] OP_SUM = 2'd0;
    localparam logic [1:0] OP_MIN = 2'd1;
    localparam logic [1:0] OP_MAX = 2'd2;

    localparam logic [CNT_W-1:0]        CNT_ONES = {CNT_W{1'b1}};
    localparam logic signed [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

    logic [1:0]              state, state_nx;
    logic [1:0]              op_q, op_nx;
    logic signed [ACC_W-1:0] acc, acc_nx;
    logic [CNT_W-1:0]        count, cnt_nx, cnt_sat;
    logic                    ovf, ovf_nx;
    logic                    ready_q, valid_q;
    logic                    beat;
    logic signed [DATA_W-1:0] din;
    logic signed [ACC_W-1:0] din_ext;
    logic signed [SUM_W-1:0] sum_ext;
    logic                    sum_wrap;

    assign din      = bus.in_data;
    assign din_ext  = ACC_W'(din);
    assign beat     = bus.in_valid & ready_q;
    assign sum_ext  = SUM_W'(acc) + SUM_W'(din_ext);
    assign sum_wrap = sum_ext[ACC_W] != sum_ext[ACC_W-1];
    assign cnt_sat  = (count == CNT_ONES) ? count : count + CNT_W'(1);

    // State and datapath registers; all outputs come straight from here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            op_q    <= OP_SUM;
            acc     <= '0;
            count   <= '0;
            ovf     <= 1'b0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_nx;
            op_q    <= op_nx;
            acc     <= acc_nx;
            count   <= cnt_nx;
            ovf     <= ovf_nx;
            ready_q <= (state_nx != S_HOLD);
            valid_q <= (state_nx == S_HOLD);
        end
    end

    // Next state and accumulator update.
    always_comb begin
        state_nx = state;
        op_nx    = op_q;
        acc_nx   = acc;
        cnt_nx   = count;
        ovf_nx   = ovf;
        case (state)
            S_IDLE: begin
                if (beat) begin
                    op_nx    = bus.op;
                    acc_nx   = (bus.op == 2'd3) ? ACC_W'(1) : din_ext;
                    cnt_nx   = CNT_W'(1);
                    ovf_nx   = (CNT_ONES == CNT_W'(1));
                    state_nx = bus.in_last ? S_HOLD : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (beat) begin
                    cnt_nx = cnt_sat;
                    ovf_nx = ovf | (cnt_sat == CNT_ONES);
                    case (op_q)
                        OP_SUM: begin
                            acc_nx = sum_ext[ACC_W-1:0];
                            if (sum_wrap) begin
                                ovf_nx = 1'b1;
`ifdef COLUMN_REDUCE_SAT_EN
                                acc_nx = sum_ext[ACC_W] ? ACC_MIN : ACC_MAX;
`endif
                            end
                        end
                        OP_MIN:  acc_nx = (din_ext < acc) ? din_ext : acc;
                        OP_MAX:  acc_nx = (din_ext > acc) ? din_ext : acc;
                        default: acc_nx = ACC_W'(cnt_sat);
                    endcase
                    if (bus.in_last) state_nx = S_HOLD;
                end
            end
            S_HOLD: begin
                if (bus.out_ready) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign bus.in_ready   = ready_q;
    assign bus.out_valid  = valid_q;
    assign bus.out_result = acc;
    assign bus.out_count  = count;
    assign bus.overflow   = ovf;
endmodule

// File: tb/tb_column_reduce.sv
// Directed bench for column_reduce with DATA_W=ACC_W=8, CNT_W=4.
module tb_column_reduce;
    localparam logic [1:0] SUM = 2'd0, MIN = 2'd1, MAX = 2'd2, CNT = 2'd3;
`ifdef COLUMN_REDUCE_SAT_EN
    localparam longint EXP_POS_OVF = 127;
    localparam longint EXP_NEG_OVF = -128;
`else
    localparam longint EXP_POS_OVF = -56;
    localparam longint EXP_NEG_OVF = 56;
`endif

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   failures = 0;

    column_reduce_if #(.DATA_W(8), .ACC_W(8), .CNT_W(4)) bus ();

    column_reduce #(.DATA_W(8), .ACC_W(8), .CNT_W(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Present a beat at the current negedge; returns at the negedge after it is accepted.
    task automatic send_beat(input int d, input logic l, input logic [1:0] o);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'(d);
        bus.in_last  = l;
        bus.op       = o;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("beat_ready", longint'(bus.in_ready), 1);
        @(negedge clk);
    endtask

    task automatic drop();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_data  = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic take(input string tag, input longint res, input longint cnt, input longint ov);
        check({tag, "_valid"}, longint'(bus.out_valid), 1);
        check({tag, "_result"}, longint'(bus.out_result), res);
        check({tag, "_count"}, longint'(bus.out_count), cnt);
        check({tag, "_ovf"}, longint'(bus.overflow), ov);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, "_valid_drop"}, longint'(bus.out_valid), 0);
        check({tag, "_ready_back"}, longint'(bus.in_ready), 1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_in_ready"}, longint'(bus.in_ready), 0);
        check({tag, "_out_valid"}, longint'(bus.out_valid), 0);
        check({tag, "_result"}, longint'(bus.out_result), 0);
        check({tag, "_count"}, longint'(bus.out_count), 0);
        check({tag, "_ovf"}, longint'(bus.overflow), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.op        = SUM;
        bus.out_ready = 1'b0;
        idle(2);
        check_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", longint'(bus.in_ready), 1);

        // SUM back-to-back, result one cycle after the last beat
        send_beat(3, 1'b0, SUM);
        check("sum_not_yet_valid", longint'(bus.out_valid), 0);
        send_beat(-5, 1'b0, SUM);
        send_beat(10, 1'b1, SUM);
        drop();
        check("sum_ready_low", longint'(bus.in_ready), 0);
        take("sum", 8, 3, 0);

        // MIN / MAX with idle gaps
        send_beat(7, 1'b0, MIN); drop(); idle(2);
        send_beat(-2, 1'b0, MIN); drop(); idle(1);
        send_beat(4, 1'b1, MIN); drop();
        take("min", -2, 3, 0);
        send_beat(7, 1'b0, MAX); drop(); idle(3);
        send_beat(-2, 1'b0, MAX);
        send_beat(4, 1'b1, MAX); drop();
        take("max", 7, 3, 0);

        // Single-beat COUNT frame goes straight to HOLD
        send_beat(99, 1'b1, CNT); drop();
        check("cnt1_ready_low", longint'(bus.in_ready), 0);
        take("count1", 1, 1, 0);

        // Backpressure: result held, pending beat not consumed
        send_beat(20, 1'b0, SUM);
        send_beat(22, 1'b1, SUM);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'(50);
        bus.in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", longint'(bus.out_valid), 1);
            check("bp_result", longint'(bus.out_result), 42);
            check("bp_count", longint'(bus.out_count), 2);
            check("bp_in_ready", longint'(bus.in_ready), 0);
        end
        drop();
        take("bp", 42, 2, 0);
        send_beat(1, 1'b1, SUM); drop();
        take("after_bp", 1, 1, 0);

        // SUM overflow both directions, then cleared on next frame
        send_beat(100, 1'b0, SUM);
        send_beat(100, 1'b1, SUM); drop();
        take("ovf_pos", EXP_POS_OVF, 2, 1);
        send_beat(1, 1'b1, SUM); drop();
        take("ovf_clear", 1, 1, 0);
        send_beat(-100, 1'b0, SUM);
        send_beat(-100, 1'b1, SUM); drop();
        take("ovf_neg", EXP_NEG_OVF, 2, 1);

        // op change mid-frame ignored
        send_beat(1, 1'b0, SUM);
        send_beat(2, 1'b1, MAX); drop();
        take("op_latch", 3, 2, 0);

        // COUNT saturates at 15 with CNT_W=4
        for (int i = 0; i < 17; i++) send_beat(i, i == 16, CNT);
        drop();
        take("count_sat", 15, 15, 1);

        // Asynchronous reset mid-frame discards the partial frame
        send_beat(40, 1'b0, SUM);
        send_beat(50, 1'b0, SUM);
        drop();
        #2;
        reset_n = 1'b0;
        #1;
        check_zero("mid_reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        send_beat(5, 1'b1, SUM); drop();
        take("post_reset", 5, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
